// File: rtl/adc_pkg.sv
// Shared state encoding and default geometry
// for the multi-channel SPI ADC reader.
package adc_pkg;

  localparam int NCH_D    = 2;
  localparam int DW_D     = 12;
  localparam int LZ_D     = 4;
  localparam int CLKDIV_D = 1;
  localparam int QUIET_D  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SHIFT,
    S_LAST,
    S_DONE,
    S_QUIET
  } state_t;

endpackage

// File: rtl/adc_spi_multi_chan.sv
// Per-channel shadow capture and output
// holding register for adc_spi_multi.
module adc_chan_shift
  import adc_pkg::*;
#(
  parameter int DW = DW_D,
  parameter int IW = $clog2(DW)
) (
  input  logic          adcclk,
  input  logic          adcrst,
  input  logic          cap,
  input  logic          load,
  input  logic [IW-1:0] sidx,
  input  logic          adcd,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] shadow;

  always_ff @(posedge adcclk) begin
    if (adcrst) begin
      shadow <= '0;
      dout   <= '0;
    end else begin
      if (cap)
        shadow[sidx] <= adcd;
      if (load)
        dout <= shadow;
    end
  end

endmodule

// File: rtl/adc_spi_multi.sv
// Shared-SCK/CS reader for NCH serial ADCs,
// single-shot or continuous conversion.
module adc_spi_multi
  import adc_pkg::*;
#(
  parameter int NCH    = NCH_D,
  parameter int DW     = DW_D,
  parameter int LZ     = LZ_D,
  parameter int CLKDIV = CLKDIV_D,
  parameter int QUIET  = QUIET_D
) (
  input  logic              adcclk,
  input  logic              adcrst,
  input  logic              adcdav,
  input  logic              contmode,
  output logic              davadc,
  output logic [NCH*DW-1:0] adcdata,
  output logic [15:0]       smpcnt,
  output logic              adcsck,
  output logic              adccs,
  input  logic [NCH-1:0]    adcd
);

  localparam int NB = LZ + DW;
  localparam int BW = $clog2(NB + 1);
  localparam int IW = $clog2(DW);
  localparam logic [BW-1:0] NBV  = BW'(NB);
  localparam logic [BW-1:0] LZV  = BW'(LZ);
  localparam logic [7:0]    DIVM = 8'(CLKDIV - 1);
  localparam logic [7:0]    QM   = 8'(QUIET - 1);

  state_t        st, st_n;
  logic [7:0]    div, div_n;
  logic [BW-1:0] bitc, bitc_n;
  logic          sck_n, cs_n, dav_n;
  logic          cmode, cmode_n;
  logic          cap, load;
  logic [IW-1:0] sidx;

  // bitc holds the current SCK period number k (1-based)
  assign sidx = IW'(NBV - bitc);

  always_ff @(posedge adcclk) begin
    if (adcrst) begin
      st     <= S_IDLE;
      div    <= '0;
      bitc   <= '0;
      adcsck <= 1'b1;
      adccs  <= 1'b1;
      davadc <= 1'b0;
      cmode  <= 1'b0;
      smpcnt <= '0;
    end else begin
      st     <= st_n;
      div    <= div_n;
      bitc   <= bitc_n;
      adcsck <= sck_n;
      adccs  <= cs_n;
      davadc <= dav_n;
      cmode  <= cmode_n;
      if (load)
        smpcnt <= smpcnt + 16'd1;
    end
  end

  always_comb begin
    st_n    = st;
    div_n   = div;
    bitc_n  = bitc;
    sck_n   = adcsck;
    cs_n    = adccs;
    dav_n   = 1'b0;
    cmode_n = cmode;
    cap     = 1'b0;
    load    = 1'b0;
    unique case (st)
      S_IDLE: begin
        sck_n = 1'b1;
        cs_n  = 1'b1;
        dav_n = davadc & adcdav;
        if (adcdav && !davadc) begin
          st_n    = S_START;
          cs_n    = 1'b0;
          cmode_n = contmode;
        end
      end
      S_START: begin
        st_n   = S_SHIFT;
        sck_n  = 1'b0;
        div_n  = '0;
        bitc_n = BW'(1);
      end
      S_SHIFT: begin
        cap = !adcsck && (div == 8'd0) && (bitc > LZV);
        if (div != DIVM) begin
          div_n = div + 8'd1;
        end else begin
          div_n = '0;
          sck_n = !adcsck;
          if (!adcsck && bitc == NBV)
            st_n = S_LAST;
          else if (adcsck)
            bitc_n = bitc + 1'b1;
        end
      end
      S_LAST: begin
        if (div != DIVM) begin
          div_n = div + 8'd1;
        end else begin
          div_n = '0;
          st_n  = S_DONE;
          cs_n  = 1'b1;
        end
      end
      S_DONE: begin
        load  = 1'b1;
        dav_n = 1'b1;
        div_n = '0;
        st_n  = cmode ? S_QUIET : S_IDLE;
      end
      S_QUIET: begin
        if (div != QM) begin
          div_n = div + 8'd1;
        end else begin
          div_n = '0;
          st_n  = S_IDLE;
          if (adcdav) begin
            st_n    = S_START;
            cs_n    = 1'b0;
            cmode_n = contmode;
          end
        end
        if (!adcdav) begin
          st_n  = S_IDLE;
          div_n = '0;
          cs_n  = 1'b1;
        end
      end
      default: st_n = S_IDLE;
    endcase
    // dropping the request mid-frame abandons it
    if (!adcdav && (st == S_START || st == S_SHIFT
                    || st == S_LAST)) begin
      st_n  = S_IDLE;
      sck_n = 1'b1;
      cs_n  = 1'b1;
      cap   = 1'b0;
      div_n = '0;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    adc_chan_shift #(.DW(DW), .IW(IW)) u_ch (
      .adcclk (adcclk),
      .adcrst (adcrst),
      .cap    (cap),
      .load   (load),
      .sidx   (sidx),
      .adcd   (adcd[i]),
      .dout   (adcdata[i*DW +: DW])
    );
  end

endmodule
